pipe_hazard_ctrl: RTL and testbench

//  Sequences the four pipeline register banks (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 26 ++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    // Resolve the MEM-stage branch/jump condition from the latched ALU flags.
    function automatic logic branch_taken(
        input logic bbeq,
        input logic bbne,
        input logic bblez,
        input logic bbgtz,
        input logic jump,
        input logic zero,
        input logic neg
    );
        return (bbeq & zero) | (bbne & ~zero) | (bblez & (zero | neg))
             | (bbgtz & ~zero & ~neg) | jump;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
// Latency: count visible one cycle after inc.
// Backpressure: none; inc is ignored once saturated, clr wins over inc.
module pipe_hazard_ctrl_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Count up until all-ones, never wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline bank enable/flush sequencer: load-use stalls, MEM-stage redirects, memory freeze.
// Latency: outputs are combinational from state + inputs; counters update one cycle later.
// Backpressure: a pending data-memory access freezes every bank until mem_ready.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REGW    = 5,
    parameter int CNTW    = 16,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_uses_rt,
    input  logic            ex_memrd,
    input  logic [REGW-1:0] ex_rd,
    input  logic            mem_memrd,
    input  logic            mem_memwr,
    input  logic            mem_ready,
    input  logic            mem_bbne,
    input  logic            mem_bbeq,
    input  logic            mem_bblez,
    input  logic            mem_bbgtz,
    input  logic            mem_jump,
    input  logic            mem_zero,
    input  logic            mem_neg,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            idex_en,
    output logic            exmem_en,
    output logic            memwb_en,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            exmem_flush,
    output logic            memwb_flush,
    output logic            pc_redirect,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt,
    output logic            mem_timeout
);

    localparam int WAITW = $clog2(TIMEOUT) + 1;

    state_t            state;
    state_t            state_nxt;
    logic              memwait;
    logic              taken;
    logic              loaduse;
    logic              hold;
    logic              stall_inc;
    logic              flush_inc;
    logic              wait_inc;
    logic              wait_clr;
    logic [WAITW-1:0]  wait_cnt;

    assign memwait = (mem_memrd | mem_memwr) & ~mem_ready;
    assign taken   = branch_taken(mem_bbeq, mem_bbne, mem_bblez, mem_bbgtz,
                                  mem_jump, mem_zero, mem_neg);
    assign loaduse = ex_memrd & (ex_rd != '0)
                   & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
    // Once frozen, only mem_ready releases the pipe (the MEM controls are frozen too).
    assign hold    = (state == ST_MEM_WAIT) ? ~mem_ready : memwait;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and bank controls; memwait outranks redirect, redirect outranks load-use.
    always_comb begin
        state_nxt   = state;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        pc_redirect = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        wait_inc    = 1'b0;
        wait_clr    = 1'b0;
        case (state)
            ST_RUN, ST_MEM_WAIT: begin
                if (hold) begin
                    memwb_flush = 1'b1;
                    wait_inc    = (state == ST_MEM_WAIT);
                    state_nxt   = ST_MEM_WAIT;
                end else begin
                    pc_en     = 1'b1;
                    ifid_en   = 1'b1;
                    idex_en   = 1'b1;
                    exmem_en  = 1'b1;
                    memwb_en  = 1'b1;
                    wait_clr  = 1'b1;
                    state_nxt = ST_RUN;
                    if (taken) begin
                        pc_redirect = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (loaduse) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                    end
                end
            end
            default: begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                memwb_flush = 1'b1;
                state_nxt   = ST_RUN;
            end
        endcase
    end

    // Sticky timeout on the TIMEOUT-th consecutive not-ready MEM_WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_timeout <= 1'b0;
        end else if (wait_inc && (wait_cnt == WAITW'(TIMEOUT - 1))) begin
            mem_timeout <= 1'b1;
        end
    end

    pipe_hazard_ctrl_sat_counter #(.W(CNTW)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (stall_inc),
        .q     (stall_cnt)
    );

    pipe_hazard_ctrl_sat_counter #(.W(CNTW)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (flush_inc),
        .q     (flush_cnt)
    );

    pipe_hazard_ctrl_sat_counter #(.W(WAITW)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wait_clr),
        .inc   (wait_inc),
        .q     (wait_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic against a reference model.
// Latency: model predicts combinational outputs each cycle and registered counters after the edge.
// Backpressure: mem_ready is randomised and held low for long stretches.
module tb_pipe_hazard_ctrl;

    localparam int REGW    = 5;
    localparam int CNTW    = 4;
    localparam int TIMEOUT = 64;
    localparam int CMAX    = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [REGW-1:0] id_rs, id_rt, ex_rd;
    logic            id_uses_rt, ex_memrd, mem_memrd, mem_memwr, mem_ready;
    logic            mem_bbne, mem_bbeq, mem_bblez, mem_bbgtz, mem_jump, mem_zero, mem_neg;
    logic            pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic            ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_redirect;
    logic [CNTW-1:0] stall_cnt, flush_cnt;
    logic            mem_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, expressed as the pipe's observable situation.
    bit m_init;      // the one-cycle start-up bubble is pending
    bit m_frozen;    // a memory access is outstanding
    int m_wait;      // consecutive not-ready cycles while frozen
    int m_stalls, m_flushes;
    bit m_tmo;

    pipe_hazard_ctrl #(.REGW(REGW), .CNTW(CNTW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memrd(ex_memrd), .ex_rd(ex_rd),
        .mem_memrd(mem_memrd), .mem_memwr(mem_memwr), .mem_ready(mem_ready),
        .mem_bbne(mem_bbne), .mem_bbeq(mem_bbeq), .mem_bblez(mem_bblez),
        .mem_bbgtz(mem_bbgtz), .mem_jump(mem_jump),
        .mem_zero(mem_zero), .mem_neg(mem_neg),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .pc_redirect(pc_redirect),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic bit m_frozen_now();
        if (m_init) return 1'b0;
        if (m_frozen) return !mem_ready;
        return (mem_memrd || mem_memwr) && !mem_ready;
    endfunction

    function automatic bit m_taken();
        bit lez, gtz;
        lez = mem_zero || mem_neg;        // value <= 0
        gtz = !mem_zero && !mem_neg;      // value > 0
        return (mem_bbeq && mem_zero) || (mem_bbne && !mem_zero) ||
               (mem_bblez && lez) || (mem_bbgtz && gtz) || mem_jump;
    endfunction

    function automatic bit m_loaduse();
        if (!ex_memrd || ex_rd == 0) return 1'b0;
        return (ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt);
    endfunction

    // Predict every output from the model and the inputs currently applied.
    task automatic compare_all();
        bit en_all, fl_if, fl_id, fl_ex, fl_wb, redir, stall;
        en_all = 0; fl_if = 0; fl_id = 0; fl_ex = 0; fl_wb = 0; redir = 0; stall = 0;
        if (m_init) begin
            fl_if = 1; fl_id = 1; fl_ex = 1; fl_wb = 1;
        end else if (m_frozen_now()) begin
            fl_wb = 1;
        end else begin
            en_all = 1;
            if (m_taken()) begin
                redir = 1; fl_if = 1; fl_id = 1; fl_ex = 1;
            end else if (m_loaduse()) begin
                stall = 1; fl_id = 1;
            end
        end
        chk("pc_en",       int'(pc_en),       int'(en_all && !stall));
        chk("ifid_en",     int'(ifid_en),     int'(en_all && !stall));
        chk("idex_en",     int'(idex_en),     int'(en_all));
        chk("exmem_en",    int'(exmem_en),    int'(en_all));
        chk("memwb_en",    int'(memwb_en),    int'(en_all));
        chk("ifid_flush",  int'(ifid_flush),  int'(fl_if));
        chk("idex_flush",  int'(idex_flush),  int'(fl_id));
        chk("exmem_flush", int'(exmem_flush), int'(fl_ex));
        chk("memwb_flush", int'(memwb_flush), int'(fl_wb));
        chk("pc_redirect", int'(pc_redirect), int'(redir));
        chk("stall_cnt",   int'(stall_cnt),   m_stalls);
        chk("flush_cnt",   int'(flush_cnt),   m_flushes);
        chk("mem_timeout", int'(mem_timeout), int'(m_tmo));
    endtask

    // Advance the model across one clock edge with the current inputs.
    task automatic model_edge();
        if (m_init) begin
            m_init = 0;
        end else if (m_frozen_now()) begin
            if (m_frozen) begin
                m_wait++;
                if (m_wait >= TIMEOUT) m_tmo = 1;
            end
            m_frozen = 1;
        end else begin
            m_frozen = 0;
            m_wait   = 0;
            if (m_taken()) begin
                if (m_flushes < CMAX) m_flushes++;
            end else if (m_loaduse()) begin
                if (m_stalls < CMAX) m_stalls++;
            end
        end
    endtask

    // Called just after a rising edge with inputs already applied.
    task automatic step();
        #4;
        compare_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; id_uses_rt = 0; ex_memrd = 0; ex_rd = '0;
        mem_memrd = 0; mem_memwr = 0; mem_ready = 1;
        mem_bbne = 0; mem_bbeq = 0; mem_bblez = 0; mem_bbgtz = 0; mem_jump = 0;
        mem_zero = 0; mem_neg = 0;
    endtask

    // Asynchronous reset from mid-cycle; outputs must go to INIT at once.
    task automatic do_reset();
        rst_n = 1'b0;
        m_init = 1; m_frozen = 0; m_wait = 0; m_stalls = 0; m_flushes = 0; m_tmo = 0;
        #1;
        compare_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic randomize_inputs();
        id_rs      = REGW'($urandom_range(0, 3));
        id_rt      = REGW'($urandom_range(0, 3));
        ex_rd      = REGW'($urandom_range(0, 3));
        id_uses_rt = 1'($urandom);
        ex_memrd   = ($urandom_range(0, 2) == 0);
        mem_memrd  = ($urandom_range(0, 5) == 0);
        mem_memwr  = ($urandom_range(0, 7) == 0);
        mem_ready  = ($urandom_range(0, 3) != 0);
        mem_bbeq   = ($urandom_range(0, 7) == 0);
        mem_bbne   = ($urandom_range(0, 7) == 0);
        mem_bblez  = ($urandom_range(0, 7) == 0);
        mem_bbgtz  = ($urandom_range(0, 7) == 0);
        mem_jump   = ($urandom_range(0, 15) == 0);
        mem_zero   = 1'($urandom);
        mem_neg    = 1'($urandom);
    endtask

    initial begin
        idle();
        #2;
        do_reset();
        // Start-up bubble, then free running.
        step();
        step();
        // Load-use on rs, then a bubble, then ex_rd = 0 must not stall.
        ex_memrd = 1; ex_rd = 5'd5; id_rs = 5'd5;
        step();
        idle(); step();
        ex_memrd = 1; ex_rd = '0; id_rs = '0;
        step();
        // Taken beq, then untaken bgtz with a negative operand.
        idle(); mem_bbeq = 1; mem_zero = 1;
        step();
        idle(); mem_bbgtz = 1; mem_neg = 1;
        step();
        // Three not-ready cycles, then the access completes.
        idle(); mem_memrd = 1; mem_ready = 0;
        repeat (3) step();
        mem_ready = 1;
        step();
        // Jump held off by a memory wait, taken once released.
        idle(); mem_memwr = 1; mem_ready = 0; mem_jump = 1;
        repeat (2) step();
        mem_ready = 1;
        step();
        // Long wait trips the timeout, which stays set afterwards.
        idle(); mem_memrd = 1; mem_ready = 0;
        repeat (TIMEOUT + 3) step();
        idle();
        repeat (3) step();
        // Reset in the middle of a wait.
        mem_memrd = 1; mem_ready = 0;
        repeat (4) step();
        do_reset();
        idle();
        step();
        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            if ($urandom_range(0, 799) == 0) begin
                do_reset();
                randomize_inputs();
            end
            step();
        end
        // Long random-free wait to recheck timeout after random traffic.
        idle(); mem_memwr = 1; mem_ready = 0;
        repeat (TIMEOUT + 2) step();
        idle();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
